trolley_system_pio_in_debounced: RTL and testbench

- Parametrised, multi-channel successor to the single-bit button input PIO; Avalon-MM slave in the trolley_system Qsys fabric.
- Each channel: 2-FF synchroniser, per-channel counter debouncer, runtime-selectable edge detector.
- Per-bit write-1-to-clear edge capture; interrupt output selectable between edge-driven and level-driven.

---
 rtl/trolley_system_pio_pkg.sv | 27 ++
 rtl/trolley_system_pio_debounce_ch.sv | 70 +++++++
 rtl/trolley_system_pio_in_debounced.sv | 120 ++++++++++++
 tb/tb_trolley_system_pio_in_debounced.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/trolley_system_pio_pkg.sv
// Shared definitions for the trolley_system debounced input PIO.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: register word addresses, edge-select encodings, register reset values.
package trolley_system_pio_pkg;

  // Word addresses of the slave register map
  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_EDGE_SEL     = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RAW          = 3'd4;

  // Which debounced transitions are recorded in EDGE_CAPTURE
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2,
    EDGE_NONE = 2'd3
  } edge_sel_e;

  // Reset values of the software-visible registers
  localparam logic [31:0] READDATA_RST = 32'd0;
  localparam logic        IRQ_MASK_BIT_RST = 1'b0;
  localparam logic        CAPTURE_BIT_RST  = 1'b0;

endpackage

// File: rtl/trolley_system_pio_debounce_ch.sv
// One input channel: 2-FF synchroniser, counter debouncer, edge detector.
// Latency: in_raw -> stable_o is 2 + DEBOUNCE_CYCLES clocks; rise/fall valid the cycle after stable moves.
// Backpressure: none; the channel samples every clock.
// Ports: clk, reset (async active-high), in_raw (asynchronous pin),
//        sync_o (synchronised pin), stable_o (debounced level), rise_o/fall_o (one-cycle edge pulses).
module trolley_system_pio_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic sync_o,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  // Terminal count; only meaningful when debouncing is enabled
  localparam int CNT_LAST_INT = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_INT);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = in_raw;
    sync2_d  = sync1_q;
    prev_d   = stable_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (DEBOUNCE_CYCLES == 0) begin
      stable_d = sync2_q;
    end else if (sync2_q != stable_q) begin
      // Any return to the stable level falls into the default above and
      // restarts the count, so short glitches never reach stable.
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= IDLE_LEVEL;
      sync2_q  <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      prev_q   <= IDLE_LEVEL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync_o   = sync2_q;
  assign stable_o = stable_q;
  assign rise_o   = stable_q & ~prev_q;
  assign fall_o   = ~stable_q & prev_q;

endmodule

// File: rtl/trolley_system_pio_in_debounced.sv
// Multi-channel debounced input PIO with edge capture and interrupt, Avalon-MM slave.
// Latency: registered read data, 1 clock; pin to DATA 2 + DEBOUNCE_CYCLES clocks.
// Backpressure: none; slave accepts every access, no waitrequest.
// Ports: clk, reset (async active-high), address/chipselect/write_n/writedata (slave write side),
//        in_port (raw pins), readdata (registered, zero-extended), irq (from registers only).
module trolley_system_pio_in_debounced
  import trolley_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int EDGE_DEFAULT    = 1,
  parameter bit IRQ_ON_EDGE     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_sel_e EDGE_SEL_RST = edge_sel_e'(2'(EDGE_DEFAULT));

  logic [WIDTH-1:0] sync_vec;
  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    trolley_system_pio_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .in_raw   (in_port[i]),
      .sync_o   (sync_vec[i]),
      .stable_o (stable_vec[i]),
      .rise_o   (rise_vec[i]),
      .fall_o   (fall_vec[i])
    );
  end

  edge_sel_e        edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] capture_clr;

  // Only the low bits of writedata carry register content
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edge_det    = '0;
    capture_clr = '0;
    edge_sel_d  = edge_sel_q;
    irq_mask_d  = irq_mask_q;
    readdata_d  = READDATA_RST;

    case (edge_sel_q)
      EDGE_RISE: edge_det = rise_vec;
      EDGE_FALL: edge_det = fall_vec;
      EDGE_ANY:  edge_det = rise_vec | fall_vec;
      default:   edge_det = '0;
    endcase

    if (wr_en) begin
      case (address)
        ADDR_EDGE_SEL:     edge_sel_d  = edge_sel_e'(writedata[1:0]);
        ADDR_IRQ_MASK:     irq_mask_d  = writedata[WIDTH-1:0];
        ADDR_EDGE_CAPTURE: capture_clr = writedata[WIDTH-1:0];
        default:           ;
      endcase
    end

    // Set is applied after clear so an edge landing on a clear write survives
    capture_d = (capture_q & ~capture_clr) | edge_det;

    case (address)
      ADDR_DATA:         readdata_d = 32'(stable_vec);
      ADDR_EDGE_SEL:     readdata_d = 32'(edge_sel_q);
      ADDR_IRQ_MASK:     readdata_d = 32'(irq_mask_q);
      ADDR_EDGE_CAPTURE: readdata_d = 32'(capture_q);
      ADDR_RAW:          readdata_d = 32'(sync_vec);
      default:           readdata_d = READDATA_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_sel_q <= EDGE_SEL_RST;
      irq_mask_q <= {WIDTH{IRQ_MASK_BIT_RST}};
      capture_q  <= {WIDTH{CAPTURE_BIT_RST}};
      readdata_q <= READDATA_RST;
    end else begin
      edge_sel_q <= edge_sel_d;
      irq_mask_q <= irq_mask_d;
      capture_q  <= capture_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

  // Built from flop outputs only, so no combinational glitches from the bus
  assign irq = IRQ_ON_EDGE ? |(capture_q & irq_mask_q) : |(stable_vec & irq_mask_q);

endmodule

// File: tb/tb_trolley_system_pio_in_debounced.sv
// Directed bench for the debounced input PIO (WIDTH=4, DEBOUNCE_CYCLES=4).
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_trolley_system_pio_in_debounced;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  trolley_system_pio_in_debounced #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16),
    .IDLE_LEVEL      (1'b1),
    .EDGE_DEFAULT    (1),
    .IRQ_ON_EDGE     (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a;
    tick();
    check(tag, readdata, exp);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 4'hF;

    // Reset state
    #3;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    tick(3);
    reset = 1'b0;

    // Idle release: nothing moves over 20 cycles
    tick(20);
    rd(3'd0, 32'hF, "idle_data");
    rd(3'd3, 32'h0, "idle_capture");
    check("idle_irq", {31'd0, irq}, 32'd0);
    rd(3'd1, 32'h1, "edge_sel_default");
    rd(3'd2, 32'h0, "irq_mask_default");
    rd(3'd4, 32'hF, "raw_idle");

    // Falling edge on bit0; upper writedata bits must be ignored
    wr(3'd1, 32'hFFFF_FFF1);
    wr(3'd2, 32'hFFFF_FFF1);
    rd(3'd1, 32'h1, "edge_sel_upper_ignored");
    rd(3'd2, 32'h1, "irq_mask_upper_ignored");
    address = 3'd0;
    in_port = 4'hE;
    tick(6);
    check("data_before_latency", readdata, 32'hF);
    check("irq_before_capture", {31'd0, irq}, 32'd0);
    tick();
    check("data_after_latency", readdata, 32'hE);
    check("irq_on_fall", {31'd0, irq}, 32'd1);
    rd(3'd3, 32'h1, "capture_bit0");
    wr(3'd3, 32'h1);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd(3'd3, 32'h0, "capture_cleared");

    // 3-cycle glitch on bit1 is rejected
    in_port = 4'hC;
    tick(3);
    in_port = 4'hE;
    tick(10);
    rd(3'd0, 32'hE, "glitch_data");
    rd(3'd3, 32'h0, "glitch_capture");

    // Any-edge mode on bit2: both directions captured, W1C in between
    wr(3'd1, 32'h2);
    in_port = 4'hA;
    tick(10);
    rd(3'd3, 32'h4, "any_fall_bit2");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h0, "any_cleared_bit2");
    in_port = 4'hE;
    tick(10);
    rd(3'd3, 32'h4, "any_rise_bit2");

    // W1C of bit3 on the cycle its edge is captured: set wins, bit2 untouched
    in_port = 4'h6;
    tick(6);
    wr(3'd3, 32'h8);
    rd(3'd3, 32'hC, "collision_set_wins");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h8, "clear_one_bit_only");

    // Async reset with bit3 counter mid-count
    wr(3'd2, 32'h8);
    check("irq_masked_bit3", {31'd0, irq}, 32'd1);
    in_port = 4'hE;
    tick(4);
    check("pre_reset_mask_read", readdata, 32'h8);
    reset = 1'b1;
    #2;
    check("async_rst_readdata", readdata, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    in_port = 4'hF;
    tick(2);
    reset = 1'b0;
    tick(20);
    rd(3'd3, 32'h0, "post_rst_capture");
    rd(3'd1, 32'h1, "post_rst_edge_sel");
    rd(3'd2, 32'h0, "post_rst_mask");
    rd(3'd0, 32'hF, "post_rst_data");
    wr(3'd0, 32'h0);
    rd(3'd0, 32'hF, "data_write_ignored");
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, 32'h0, "addr5_reads_zero");
    rd(3'd3, 32'h0, "addr5_write_no_effect");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
